o_serdes_tx: RTL and testbench

//  Parallel-to-serial output serializer for the I/O tile. Captures a WIDTH-bit word on LOAD_WORD and shifts it out MSB-first on Q, one bit per enabled cycle.

---
 rtl/o_serdes_pkg.sv | 29 ++
 rtl/o_serdes_word_ctr.sv | 76 +++++++
 rtl/o_serdes_tx.sv | 96 +++++++++
 tb/tb_o_serdes_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/o_serdes_pkg.sv
// o_serdes_pkg
//   Shared definitions for the o_serdes_tx output serializer:
//   legal word-width bounds, the word-level state type and a
//   ceiling-log2 helper used to size the bit counter.
package o_serdes_pkg;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Number of bits needed to count 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/o_serdes_word_ctr.sv
// o_serdes_word_ctr
//   Word-level sequencing for o_serdes_tx: IDLE/SHIFT state, bit counter,
//   word-boundary flag and the channel-bond abort (registered rising-edge
//   detect of the bond request).
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   lock       in   PLL lock; 0 returns the counter to IDLE like reset
//   en         in   shift enable (lock & pll qualifier)
//   load_req   in   word load request
//   bond_in    in   channel-bond request level
//   state      out  current word state (debug / checker visibility)
//   boundary   out  1 when the next enabled edge may start a new word
//   load_ok    out  a load is accepted at this edge
//   abort      out  the in-flight word is cut short at this edge
module o_serdes_word_ctr
    import o_serdes_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    input  logic       en,
    input  logic       load_req,
    input  logic       bond_in,
    output ser_state_t state,
    output logic       boundary,
    output logic       load_ok,
    output logic       abort
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t    state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          bond_d;
    logic          bond_rise;

    assign bond_rise = bond_in & ~bond_d;
    assign boundary  = (state == IDLE) || (cnt == LAST);
    assign load_ok   = en & load_req & boundary;
    // A bond edge only matters mid-word; at a boundary the load proceeds.
    assign abort     = en & bond_rise & (state == SHIFT) & ~boundary;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (en) begin
            if (boundary) begin
                state_d = load_req ? SHIFT : IDLE;
                cnt_d   = '0;
            end else if (bond_rise) begin
                // Jump to the last slot so the following edge is a boundary.
                cnt_d = LAST;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !lock) begin
            state  <= IDLE;
            cnt    <= '0;
            bond_d <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (en) bond_d <= bond_in;
        end
    end

endmodule

// File: rtl/o_serdes_tx.sv
// o_serdes_tx
//   Parallel-to-serial output serializer. A WIDTH-bit word is captured at a
//   word boundary and shifted out MSB-first on Q, one bit per enabled cycle.
//   The output enable is registered with the word, and a channel-bond pulse
//   marks word starts taken while the bond request is high.
// Ports
//   CLK_IN                 in   serial bit clock
//   RST                    in   synchronous reset, active-high
//   D                      in   parallel word, D[WIDTH-1] sent first
//   LOAD_WORD              in   load request, honoured at word boundaries
//   OE_IN                  in   output enable paired with the loaded word
//   OE_OUT                 out  registered pad output enable
//   Q                      out  serial data, gated by OE_OUT
//   CHANNEL_BOND_SYNC_IN   in   lane-alignment request
//   CHANNEL_BOND_SYNC_OUT  out  one-cycle pulse on an aligned word start
//   PLL_LOCK               in   0 holds the block in its reset state
//   PLL_CLK                in   shift enable qualifier (not a clock)
module o_serdes_tx
    import o_serdes_pkg::*;
#(
    parameter string DATA_RATE = "SDR",
    parameter int    WIDTH     = 4
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_WORD,
    input  logic             OE_IN,
    output logic             OE_OUT,
    output logic             Q,
    input  logic             CHANNEL_BOND_SYNC_IN,
    output logic             CHANNEL_BOND_SYNC_OUT,
    input  logic             PLL_LOCK,
    input  logic             PLL_CLK
);

    if (DATA_RATE != "SDR") begin : g_bad_rate
        $error("o_serdes_tx: only DATA_RATE \"SDR\" is supported");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("o_serdes_tx: WIDTH out of range 3..10");
    end

    logic             en;
    logic [WIDTH-1:0] sr;
    logic             q_reg;
    ser_state_t       state;
    logic             boundary;
    logic             load_ok;
    logic             abort;
    logic             shift_ok;

    assign en       = PLL_LOCK & PLL_CLK;
    assign shift_ok = en & (state == SHIFT) & ~boundary & ~abort;

    o_serdes_word_ctr #(.WIDTH(WIDTH)) u_word_ctr (
        .clk      (CLK_IN),
        .rst      (RST),
        .lock     (PLL_LOCK),
        .en       (en),
        .load_req (LOAD_WORD),
        .bond_in  (CHANNEL_BOND_SYNC_IN),
        .state    (state),
        .boundary (boundary),
        .load_ok  (load_ok),
        .abort    (abort)
    );

    always_ff @(posedge CLK_IN) begin
        if (RST || !PLL_LOCK) begin
            q_reg                 <= 1'b0;
            sr                    <= '0;
            OE_OUT                <= 1'b0;
            CHANNEL_BOND_SYNC_OUT <= 1'b0;
        end else begin
            // Recomputed every cycle (not held) so the pulse is one cycle wide.
            CHANNEL_BOND_SYNC_OUT <= load_ok & CHANNEL_BOND_SYNC_IN;
            if (load_ok) begin
                q_reg  <= D[WIDTH-1];
                sr     <= {D[WIDTH-2:0], 1'b0};
                OE_OUT <= OE_IN;
            end else if (abort) begin
                // Aborted words stop driving data immediately.
                q_reg <= 1'b0;
            end else if (shift_ok) begin
                q_reg <= sr[WIDTH-1];
                sr    <= {sr[WIDTH-2:0], 1'b0};
            end else if (en && boundary) begin
                q_reg <= 1'b0;
            end
        end
    end

    assign Q = q_reg & OE_OUT;

endmodule

// File: tb/tb_o_serdes_tx.sv
// tb_o_serdes_tx
//   Directed self-checking bench for o_serdes_tx with WIDTH=4.
module tb_o_serdes_tx;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic       load_word;
    logic       oe_in;
    logic       oe_out;
    logic       q;
    logic       sync_in;
    logic       sync_out;
    logic       pll_lock;
    logic       pll_clk;

    int total;
    int bad;

    o_serdes_tx #(.DATA_RATE("SDR"), .WIDTH(4)) dut (
        .CLK_IN                (clk),
        .RST                   (rst),
        .D                     (d),
        .LOAD_WORD             (load_word),
        .OE_IN                 (oe_in),
        .OE_OUT                (oe_out),
        .Q                     (q),
        .CHANNEL_BOND_SYNC_IN  (sync_in),
        .CHANNEL_BOND_SYNC_OUT (sync_out),
        .PLL_LOCK              (pll_lock),
        .PLL_CLK               (pll_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        load_word = 1'b1;
        oe_in     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = 4'($urandom_range(0, 15));
            tick();
            total++;
            if (q !== 1'b0 || oe_out !== 1'b0 || sync_out !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc%0d: q=%b oe=%b sync=%b want 0 0 0", i, q, oe_out, sync_out);
            end
        end
        rst       = 1'b0;
        load_word = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        logic [3:0] exp_bits;
        exp_bits  = 4'b0101;
        d         = 4'b0101;
        oe_in     = 1'b1;
        load_word = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            load_word = 1'b0;
            total++;
            if (q !== exp_bits[3-i] || oe_out !== 1'b1) begin
                bad++;
                $display("FAIL single bit%0d: q=%b oe=%b want %b 1", i, q, oe_out, exp_bits[3-i]);
            end
        end
        tick();
        total++;
        if (q !== 1'b0 || oe_out !== 1'b1) begin
            bad++;
            $display("FAIL single idle: q=%b oe=%b want 0 1", q, oe_out);
        end
    endtask

    task automatic test_streaming();
        logic [3:0] cur;
        load_word = 1'b1;
        oe_in     = 1'b1;
        for (int w = 0; w < 500; w++) begin
            cur = 4'($urandom_range(0, 15));
            d   = cur;
            for (int i = 0; i < 4; i++) begin
                tick();
                // Mid-word data changes must not disturb the word in flight.
                d = 4'($urandom_range(0, 15));
                total++;
                if (q !== cur[3-i]) begin
                    bad++;
                    $display("FAIL stream w%0d bit%0d: q=%b want %b", w, i, q, cur[3-i]);
                end
            end
        end
        load_word = 1'b0;
        tick();
        total++;
        if (q !== 1'b0) begin
            bad++;
            $display("FAIL stream end: q=%b want 0", q);
        end
    endtask

    task automatic test_oe_gating();
        d         = 4'b1111;
        oe_in     = 1'b0;
        load_word = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            load_word = 1'b0;
            total++;
            if (q !== 1'b0 || oe_out !== 1'b0) begin
                bad++;
                $display("FAIL oe_gate bit%0d: q=%b oe=%b want 0 0", i, q, oe_out);
            end
        end
        tick();
        oe_in = 1'b1;
    endtask

    task automatic test_pll_lock();
        logic [3:0] w2;
        logic [3:0] w3;
        d         = 4'b1011;
        oe_in     = 1'b1;
        load_word = 1'b1;
        tick();
        load_word = 1'b0;
        total++;
        if (q !== 1'b1) begin
            bad++;
            $display("FAIL lock pre bit0: q=%b want 1", q);
        end
        tick();
        pll_lock = 1'b0;
        tick();
        total++;
        if (q !== 1'b0 || oe_out !== 1'b0 || sync_out !== 1'b0) begin
            bad++;
            $display("FAIL lock drop: q=%b oe=%b sync=%b want 0 0 0", q, oe_out, sync_out);
        end
        pll_lock = 1'b1;
        tick();
        total++;
        if (q !== 1'b0 || oe_out !== 1'b0) begin
            bad++;
            $display("FAIL lock relock idle: q=%b oe=%b want 0 0", q, oe_out);
        end
        w2        = 4'b0110;
        d         = w2;
        load_word = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            load_word = 1'b0;
            total++;
            if (q !== w2[3-i] || oe_out !== 1'b1) begin
                bad++;
                $display("FAIL lock reload bit%0d: q=%b oe=%b want %b 1", i, q, oe_out, w2[3-i]);
            end
        end
        tick();
        // Half-rate: PLL_CLK alternates, each bit is held for two cycles.
        w3 = 4'b1001;
        d  = w3;
        for (int i = 0; i < 4; i++) begin
            pll_clk   = 1'b1;
            load_word = (i == 0);
            tick();
            load_word = 1'b0;
            total++;
            if (q !== w3[3-i]) begin
                bad++;
                $display("FAIL halfrate bit%0d a: q=%b want %b", i, q, w3[3-i]);
            end
            pll_clk = 1'b0;
            tick();
            total++;
            if (q !== w3[3-i]) begin
                bad++;
                $display("FAIL halfrate bit%0d b: q=%b want %b", i, q, w3[3-i]);
            end
        end
        pll_clk = 1'b1;
        tick();
        total++;
        if (q !== 1'b0) begin
            bad++;
            $display("FAIL halfrate end: q=%b want 0", q);
        end
    endtask

    task automatic test_bond();
        sync_in   = 1'b0;
        oe_in     = 1'b1;
        d         = 4'b1010;
        load_word = 1'b1;
        tick();
        total++;
        if (q !== 1'b1 || sync_out !== 1'b0) begin
            bad++;
            $display("FAIL bond load1: q=%b sync=%b want 1 0", q, sync_out);
        end
        tick();
        // Word is now at cnt=1; raise the bond request.
        sync_in = 1'b1;
        d       = 4'b1100;
        tick();
        total++;
        if (q !== 1'b0 || sync_out !== 1'b0) begin
            bad++;
            $display("FAIL bond abort: q=%b sync=%b want 0 0", q, sync_out);
        end
        tick();
        load_word = 1'b0;
        total++;
        if (q !== 1'b1 || sync_out !== 1'b1) begin
            bad++;
            $display("FAIL bond reload: q=%b sync=%b want 1 1", q, sync_out);
        end
        tick();
        total++;
        if (q !== 1'b1 || sync_out !== 1'b0) begin
            bad++;
            $display("FAIL bond pulse_end: q=%b sync=%b want 1 0", q, sync_out);
        end
        tick();
        total++;
        if (q !== 1'b0 || sync_out !== 1'b0) begin
            bad++;
            $display("FAIL bond bit2: q=%b sync=%b want 0 0", q, sync_out);
        end
        tick();
        tick();
        sync_in = 1'b0;
        total++;
        if (q !== 1'b0) begin
            bad++;
            $display("FAIL bond idle: q=%b want 0", q);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        d         = 4'b0000;
        load_word = 1'b0;
        oe_in     = 1'b0;
        sync_in   = 1'b0;
        pll_lock  = 1'b1;
        pll_clk   = 1'b1;
        test_reset();
        test_single_word();
        test_streaming();
        test_oe_gating();
        test_pll_lock();
        test_bond();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
